// File: rtl/htif_pcr_master.sv
`default_nettype none
// htif_pcr_master: turns a byte-serial host command stream into single PCR reads/writes
// and returns the PCR's old value as four little-endian bytes.
module htif_pcr_master #(
    parameter logic [1:0]  CMD_READ    = 2'd0,
    parameter logic [1:0]  CMD_WRITE   = 2'd1,
    parameter int unsigned GNT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        pcr_en,
    output logic [4:0]  pcr_addr,
    output logic [1:0]  pcr_cmd,
    output logic [31:0] pcr_wdata,
    input  logic [31:0] pcr_rdata,
    input  logic        pcr_gnt,
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RX_DATA = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_TX_DATA = 3'd3;
    localparam logic [2:0] S_TX_ONE  = 3'd4;

    localparam logic [7:0] TIMEOUT_LAST = 8'(GNT_TIMEOUT - 1);

    localparam logic [7:0] RESP_PING    = 8'hA5;
    localparam logic [7:0] RESP_ILLEGAL = 8'hEE;
    localparam logic [7:0] RESP_TIMEOUT = 8'hEF;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  addr_q, addr_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_q, resp_d;
    logic [7:0]  one_q, one_d;

    logic rx_acc;
    logic tx_acc;

    assign rx_ready = !reset && ((state_q == S_IDLE) || (state_q == S_RX_DATA));
    assign tx_valid = (state_q == S_TX_DATA) || (state_q == S_TX_ONE);
    assign rx_acc   = rx_valid && rx_ready;
    assign tx_acc   = tx_valid && tx_ready;

    assign pcr_en    = (state_q == S_ACCESS);
    assign pcr_addr  = addr_q;
    assign pcr_cmd   = cmd_q;
    assign pcr_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        tx_data = 8'h00;
        if (state_q == S_TX_DATA) begin
            tx_data = resp_q[{cnt_q[1:0], 3'b000} +: 8];
        end else if (state_q == S_TX_ONE) begin
            tx_data = one_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        resp_d  = resp_q;
        one_d   = one_q;

        case (state_q)
            S_IDLE: begin
                if (rx_acc) begin
                    addr_d = rx_data[4:0];
                    cnt_d  = 8'd0;
                    case (rx_data[7:5])
                        3'b000: begin
                            cmd_d   = CMD_READ;
                            state_d = S_ACCESS;
                        end
                        3'b001: begin
                            cmd_d   = CMD_WRITE;
                            state_d = S_RX_DATA;
                        end
                        3'b010: begin
                            one_d   = RESP_PING;
                            state_d = S_TX_ONE;
                        end
                        default: begin
                            one_d   = RESP_ILLEGAL;
                            state_d = S_TX_ONE;
                        end
                    endcase
                end
            end

            S_RX_DATA: begin
                if (rx_acc) begin
                    wdata_d[{cnt_q[1:0], 3'b000} +: 8] = rx_data;
                    if (cnt_q[1:0] == 2'd3) begin
                        cnt_d   = 8'd0;
                        state_d = S_ACCESS;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            // Grant is tested before the timeout so a grant in the final wait cycle still completes.
            S_ACCESS: begin
                if (pcr_gnt) begin
                    resp_d  = pcr_rdata;
                    cnt_d   = 8'd0;
                    state_d = S_TX_DATA;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    one_d   = RESP_TIMEOUT;
                    cnt_d   = 8'd0;
                    state_d = S_TX_ONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_TX_DATA: begin
                if (tx_acc) begin
                    if (cnt_q[1:0] == 2'd3) begin
                        cnt_d   = 8'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            S_TX_ONE: begin
                if (tx_acc) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 5'd0;
            cmd_q   <= CMD_READ;
            wdata_q <= 32'd0;
            resp_q  <= 32'd0;
            one_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            one_q   <= one_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_htif_pcr_master.sv
`default_nettype none
// tb_htif_pcr_master: scoreboard bench with a PCR responder model; a second instance
// with a short grant timeout covers the abort path.
module tb_htif_pcr_master;

    localparam logic [1:0] CMD_READ  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid, rx_valid2;
    logic [7:0]  rx_data;
    logic        rx_ready, rx_ready2;
    logic        tx_valid, tx_valid2;
    logic [7:0]  tx_data, tx_data2;
    logic        tx_ready;
    logic        pcr_en, pcr_en2;
    logic [4:0]  pcr_addr, pcr_addr2;
    logic [1:0]  pcr_cmd, pcr_cmd2;
    logic [31:0] pcr_wdata, pcr_wdata2;
    logic [31:0] pcr_rdata, pcr_rdata2;
    logic        pcr_gnt, pcr_gnt2;
    logic        busy, busy2;

    always #5 clk = ~clk;

    htif_pcr_master #(.CMD_READ(CMD_READ), .CMD_WRITE(CMD_WRITE), .GNT_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .pcr_en(pcr_en), .pcr_addr(pcr_addr), .pcr_cmd(pcr_cmd), .pcr_wdata(pcr_wdata),
        .pcr_rdata(pcr_rdata), .pcr_gnt(pcr_gnt), .busy(busy)
    );

    htif_pcr_master #(.CMD_READ(CMD_READ), .CMD_WRITE(CMD_WRITE), .GNT_TIMEOUT(4)) dut2 (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid2), .rx_data(rx_data), .rx_ready(rx_ready2),
        .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready),
        .pcr_en(pcr_en2), .pcr_addr(pcr_addr2), .pcr_cmd(pcr_cmd2), .pcr_wdata(pcr_wdata2),
        .pcr_rdata(pcr_rdata2), .pcr_gnt(pcr_gnt2), .busy(busy2)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Responder model: presents the old value while enabled, commits writes on the granted edge.
    logic [31:0] mem [32];
    assign pcr_rdata  = mem[pcr_addr];
    assign pcr_rdata2 = 32'h1234_5678;

    always @(posedge clk) begin
        if (!reset && pcr_en && pcr_gnt && pcr_cmd == CMD_WRITE)
            mem[pcr_addr] <= pcr_wdata;
    end

    logic [7:0]  sb [$];
    logic [4:0]  exp_addr;
    logic [1:0]  exp_cmd;
    logic [31:0] exp_wdata;
    int en_cnt, acc_cnt, en2_cnt;

    always @(negedge clk) begin
        if (!reset) begin
            if (pcr_en) en_cnt++;
            if (pcr_en2) en2_cnt++;
            if (pcr_en && pcr_gnt) begin
                acc_cnt++;
                check_val("acc_addr", 32'(pcr_addr), 32'(exp_addr));
                check_val("acc_cmd", 32'(pcr_cmd), 32'(exp_cmd));
                if (exp_cmd == CMD_WRITE) check_val("acc_wdata", pcr_wdata, exp_wdata);
            end
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) check_val("tx_extra", 32'(tx_data), 32'hFFFF_FFFF);
                else check_val("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b);
        bit ok;
        int guard;
        ok = 1'b0;
        guard = 0;
        rx_data = b;
        if (sel) rx_valid2 = 1'b1; else rx_valid = 1'b1;
        while (!ok && guard < 100) begin
            @(negedge clk);
            ok = sel ? rx_ready2 : rx_ready;
            tick();
            guard++;
        end
        rx_valid  = 1'b0;
        rx_valid2 = 1'b0;
        if (!ok) check_val("rx_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) sb.push_back(w[8*i +: 8]);
    endtask

    task automatic start_cmd(input logic [4:0] a, input logic [1:0] c, input logic [31:0] wd);
        exp_addr = a;
        exp_cmd = c;
        exp_wdata = wd;
        en_cnt = 0;
        acc_cnt = 0;
    endtask

    task automatic end_cmd(input string tag, input int exp_acc, input int exp_en);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy && !tx_valid && sb.size() == 0) done = 1'b1;
        end
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_val({tag, "_nacc"}, 32'(acc_cnt), 32'(exp_acc));
        check_val({tag, "_nen"}, 32'(en_cnt), 32'(exp_en));
        sb.delete();
        tick();
    endtask

    logic [31:0] got2;
    bit seen;

    initial begin
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_valid2 = 1'b0;
        rx_data = 8'h00;
        tx_ready = 1'b1;
        pcr_gnt = 1'b1;
        pcr_gnt2 = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mem[0] = 32'h0000_0004;
        en_cnt = 0; acc_cnt = 0; en2_cnt = 0;
        exp_addr = 5'd0; exp_cmd = CMD_READ; exp_wdata = 32'd0;

        repeat (2) tick();
        @(negedge clk);
        check_val("rst_rx_ready", 32'(rx_ready), 32'd0);
        check_val("rst_outs", {busy, tx_valid, pcr_en, tx_data, pcr_addr, pcr_cmd},
                  {1'b0, 1'b0, 1'b0, 8'h00, 5'd0, CMD_READ});
        check_val("rst_wdata", pcr_wdata, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Read addr 0 with latency checks.
        start_cmd(5'd0, CMD_READ, 32'd0);
        push_word(32'h0000_0004);
        send_byte(1'b0, 8'h00);
        check_val("lat_pcr_en", 32'(pcr_en), 32'd1);
        tick();
        check_val("lat_tx_valid", 32'(tx_valid), 32'd1);
        end_cmd("read0", 1, 1);

        // Write addr 30, then read it back.
        start_cmd(5'd30, CMD_WRITE, 32'hEFBE_ADDE);
        push_word(32'h0000_0000);
        send_byte(1'b0, 8'h3E);
        send_byte(1'b0, 8'hDE);
        send_byte(1'b0, 8'hAD);
        send_byte(1'b0, 8'hBE);
        send_byte(1'b0, 8'hEF);
        end_cmd("write30", 1, 1);

        start_cmd(5'd30, CMD_READ, 32'd0);
        push_word(32'hEFBE_ADDE);
        send_byte(1'b0, 8'h1E);
        end_cmd("read30", 1, 1);

        // Grant withheld for 10 cycles.
        pcr_gnt = 1'b0;
        start_cmd(5'd30, CMD_READ, 32'd0);
        push_word(32'hEFBE_ADDE);
        send_byte(1'b0, 8'h1E);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("cont_hold", {27'd0, pcr_en, pcr_addr}, {27'd0, 1'b1, 5'd30});
            tick();
        end
        pcr_gnt = 1'b1;
        end_cmd("contention", 1, 11);

        // Ping and illegal ops.
        start_cmd(5'd0, CMD_READ, 32'd0);
        sb.push_back(8'hA5);
        send_byte(1'b0, 8'h40);
        end_cmd("ping", 0, 0);
        sb.push_back(8'hEE);
        send_byte(1'b0, 8'hE0);
        end_cmd("illegal_e0", 0, 0);
        sb.push_back(8'hEE);
        send_byte(1'b0, 8'h65);
        end_cmd("illegal_65", 0, 0);

        // Backpressure on the first response byte.
        tx_ready = 1'b0;
        start_cmd(5'd0, CMD_READ, 32'd0);
        push_word(32'h0000_0004);
        send_byte(1'b0, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
        check_val("bp_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check_val("bp_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h04});
        end
        tick();
        tx_ready = 1'b1;
        end_cmd("backpressure", 1, 1);

        // Reset in the middle of a write's data bytes.
        start_cmd(5'd30, CMD_WRITE, 32'h0);
        send_byte(1'b0, 8'h3E);
        send_byte(1'b0, 8'h11);
        send_byte(1'b0, 8'h22);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        check_val("midrst_idle", {30'd0, busy, pcr_en}, 32'd0);
        tick();
        end_cmd("midrst", 0, 0);
        start_cmd(5'd30, CMD_READ, 32'd0);
        push_word(32'hEFBE_ADDE);
        send_byte(1'b0, 8'h1E);
        end_cmd("after_rst", 1, 1);

        // Short-timeout instance: no grant aborts after 4 enabled cycles.
        en2_cnt = 0;
        send_byte(1'b1, 8'h05);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (tx_valid2) seen = 1'b1;
        end
        check_val("to_seen", 32'(seen), 32'd1);
        check_val("to_byte", 32'(tx_data2), 32'h0000_00EF);
        check_val("to_en_cycles", 32'(en2_cnt), 32'd4);
        tick();
        @(negedge clk);
        check_val("to_idle", {30'd0, busy2, tx_valid2}, 32'd0);
        tick();

        // Grant arriving in the final wait cycle still completes the access.
        en2_cnt = 0;
        send_byte(1'b1, 8'h05);
        repeat (3) tick();
        pcr_gnt2 = 1'b1;
        tick();
        pcr_gnt2 = 1'b0;
        got2 = 32'd0;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (tx_valid2) begin
                    seen = 1'b1;
                    got2[8*k +: 8] = tx_data2;
                end
            end
            tick();
        end
        check_val("late_gnt_data", got2, 32'h1234_5678);
        check_val("late_gnt_en", 32'(en2_cnt), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/htif_pcr_master.md
Name: htif_pcr_master

Overview:
- Host-side initiator for the PCR access port (enable / pcr / cmd / write data / read data) that the control processor responds to.
- Accepts a byte-serial command stream from the host link and issues one PCR read or write per command, e.g. tohost polling or fromhost delivery.
- Returns the PCR's old value to the host as a byte stream.
- Sits between the host UART/byte bridge and the core's PCR port mux; the core pipeline has priority via pcr_gnt.

Parameters:
- CMD_READ, 2'd0: pcr_cmd encoding driven for a read; the top level overrides it from consts.vh to match the MFPCR encoding.
- CMD_WRITE, 2'd1: pcr_cmd encoding driven for a write; the top level overrides it from consts.vh to match `F3_MTPCR`.
- GNT_TIMEOUT, 255: maximum cycles pcr_en may wait for pcr_gnt before the command is aborted. Legal range 1..255; the counter is 8 bits.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- rx_valid  input  1  host command byte valid
- rx_data  input  8  host command byte
- rx_ready  output  1  block accepts rx byte this cycle
- tx_valid  output  1  response byte valid
- tx_data  output  8  response byte
- tx_ready  input  1  host link accepts tx byte
- pcr_en  output  1  PCR access request; drives the responder's enable through the port mux
- pcr_addr  output  5  PCR index
- pcr_cmd  output  2  CMD_READ or CMD_WRITE
- pcr_wdata  output  32  write data
- pcr_rdata  input  32  old PCR value, combinational from the responder while pcr_en is high
- pcr_gnt  input  1  port granted this cycle: core not stalled and not using the PCR port
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset: synchronous, active-high, clock clk.
  - Outputs: state=IDLE, rx_ready=0 during reset, tx_valid=0, tx_data=0, pcr_en=0, pcr_addr=0, pcr_cmd=CMD_READ, pcr_wdata=0, busy=0.
  - Reset mid-command discards all partial state. No response is sent and no PCR access is issued.
- Handshakes:
  - A byte transfers on rx_valid&&rx_ready, or on tx_valid&&tx_ready.
  - tx_data and tx_valid are held stable until accepted.
  - rx_ready is 1 only in IDLE and RX_DATA.
- Command byte: op=rx_data[7:5], addr=rx_data[4:0].
  - op 3'b000 = read, 3'b001 = write, 3'b010 = ping. All other values are illegal.
- States:
  - IDLE: on an accepted byte, latch addr into pcr_addr.
    - read → ACCESS, with pcr_cmd=CMD_READ.
    - write → RX_DATA, with byte counter=0 and pcr_cmd=CMD_WRITE.
    - ping → TX_ONE, with tx_data=8'hA5.
    - illegal → TX_ONE, with tx_data=8'hEE.
  - RX_DATA: collects 4 bytes little-endian into pcr_wdata (byte k → bits [8k+7:8k]). After the 4th accepted byte → ACCESS. There is no inter-byte timeout.
  - ACCESS: pcr_en=1 with addr, cmd and wdata stable. The wait counter starts at 0 on entry.
    - Access completes in the first cycle with pcr_en&&pcr_gnt. In that cycle pcr_rdata is captured into a 32-bit response register and pcr_en drops the next cycle, giving exactly one granted cycle per command → TX_DATA, with counter=0.
    - Otherwise the counter increments. On reaching GNT_TIMEOUT without a grant: pcr_en=0, no access, tx_data=8'hEF → TX_ONE.
    - If pcr_gnt arrives in the same cycle the counter reaches GNT_TIMEOUT, the grant wins.
  - TX_DATA: sends the response register as 4 bytes little-endian, LSB first. After the 4th accepted byte → IDLE.
  - TX_ONE: sends one byte; on acceptance → IDLE.
- Reads and writes both return the old PCR value, because the responder presents the pre-write value during the granted cycle.
- Commands are strictly serialized; no new rx byte is accepted until the response completes.
- Latency from last rx byte to pcr_en is 1 cycle. With pcr_gnt=1 and tx_ready=1, the first tx byte is valid 2 cycles after the last rx byte.
- pcr_en is never asserted outside ACCESS, and never for more than one granted cycle per command.

Test Plan:
- Read: status=32'h0000_0004. rx 8'h00 (read addr 0), gnt=1, tx_ready=1 → pcr_en high one cycle with addr=0, cmd=CMD_READ; tx bytes 04,00,00,00.
- Write: rx 8'h3E, then DE,AD,BE,EF, with old PCR value 0 → one granted cycle with cmd=CMD_WRITE, addr=30, wdata=32'hEFBEADDE; tx 00,00,00,00. A following read of addr 30 returns EF... bytes DE,AD,BE,EF.
- Grant contention: read command with pcr_gnt=0 for 10 cycles, then 1 → pcr_en held 11 cycles with stable addr; exactly one access; correct data returned.
- Timeout: GNT_TIMEOUT=4, pcr_gnt held 0 → pcr_en drops after 4 cycles; tx single byte 8'hEF; no register changes.
- Ping/illegal/backpressure: rx 8'h40 → tx A5. rx 8'hE0 → tx EE. During a read, hold tx_ready=0 for 5 cycles → tx_data and tx_valid stable and no byte is lost. Assert reset during RX_DATA after 2 bytes → no pcr_en, state IDLE, next command processes normally.
